// File: rtl/pool_out_writer.sv
// Buffers pooled elements in a small FIFO and writes them to the output map at base + raster index.
// Optional build macro POOL_OUT_RELU_EN clamps negative elements to zero before they are buffered.
module pool_out_writer #(
    parameter int DATA_W     = 16,
    parameter int POOL_W     = 14,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pool_valid,
    input  logic [DATA_W-1:0] pool_data,
    input  logic              pool_last,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf_err,
    output logic              cnt_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = 16;
    localparam logic [IDX_W-1:0] FRAME_LEN = IDX_W'(POOL_W * POOL_W);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ovf_err_q, ovf_err_d;
    logic              cnt_err_q, cnt_err_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [DATA_W-1:0] push_data;
    logic              push, pop, full, push_ok;

`ifdef POOL_OUT_RELU_EN
    assign push_data = pool_data[DATA_W-1] ? '0 : pool_data;
`else
    assign push_data = pool_data;
`endif

    assign pop     = wr_valid_q & wr_ready;
    assign push    = (state_q == ACTIVE) & pool_valid;
    assign full    = (count_q == DEPTH_C);
    assign push_ok = push & (~full | pop);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx_d     = idx_q;
        ovf_err_d = ovf_err_q;
        cnt_err_d = cnt_err_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        mem_d     = mem_q;

        if (push & full & ~pop) ovf_err_d = 1'b1;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            idx_d  = idx_q + 1'b1;
        end
        if (push_ok) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: if (start) begin
                state_d   = ACTIVE;
                base_d    = base_addr;
                idx_d     = '0;
                ovf_err_d = 1'b0;
                cnt_err_d = 1'b0;
            end
            ACTIVE: if (pool_last) state_d = DRAIN;
            // FIFO empty implies no write is pending, so idx is final here
            DRAIN: if (count_q == '0) begin
                state_d = DONE;
                if (idx_q != FRAME_LEN) cnt_err_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Output register follows the head the FIFO will have next cycle
        wr_valid_d = (count_d != '0);
        wr_addr_d  = base_d + idx_d[ADDR_W-1:0];
        wr_data_d  = (push_ok && (wptr_q == rptr_d)) ? push_data : mem_q[rptr_d];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            ovf_err_q  <= 1'b0;
            cnt_err_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            ovf_err_q  <= ovf_err_d;
            cnt_err_q  <= cnt_err_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q == ACTIVE) || (state_q == DRAIN);
    assign frame_done = (state_q == DONE);
    assign ovf_err    = ovf_err_q;
    assign cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_pool_out_writer.sv
// Directed bench for pool_out_writer with a write scoreboard; honours POOL_OUT_RELU_EN.
module tb_pool_out_writer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              pool_valid = 1'b0;
    logic [DATA_W-1:0] pool_data = '0;
    logic              pool_last = 1'b0;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready = 1'b0;
    logic              busy, frame_done, ovf_err, cnt_err;

    pool_out_writer dut (
        .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
        .pool_valid(pool_valid), .pool_data(pool_data), .pool_last(pool_last),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+DATA_W-1:0] sb[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    int done_cnt = 0;
    logic done_cerr = 1'b0;
    logic done_busy = 1'b0;
    int wr_cnt = 0;
    logic [DATA_W-1:0] last_wr_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d);
`ifdef POOL_OUT_RELU_EN
        return d[DATA_W-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    // Write-port monitor: scoreboard pops, hold-stability and frame_done capture
    initial begin
        logic              hold_v = 1'b0;
        logic [ADDR_W-1:0] hold_a = '0;
        logic [DATA_W-1:0] hold_d = '0;
        logic [ADDR_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v && wr_valid) begin
                    check("hold_addr", 32'(wr_addr), 32'(hold_a));
                    check("hold_data", 32'(wr_data), 32'(hold_d));
                end
                hold_v = wr_valid && !wr_ready;
                hold_a = wr_addr;
                hold_d = wr_data;
                if (wr_valid && wr_ready) begin
                    wr_cnt++;
                    last_wr_data = wr_data;
                    checks++;
                    assert (sb.size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected none", wr_addr, wr_data);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                        check("wr_data", 32'(wr_data), 32'(e[DATA_W-1:0]));
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cerr = cnt_err;
                    done_busy = busy;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        exp_addr = b;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic accept);
        pool_valid = 1'b1;
        pool_data = d;
        pool_last = last;
        if (accept) begin
            sb.push_back({exp_addr, model(d)});
            exp_addr = exp_addr + 1'b1;
        end
        tick(1);
        pool_valid = 1'b0;
        pool_last = 1'b0;
    endtask

    task automatic last_only();
        pool_last = 1'b1;
        tick(1);
        pool_last = 1'b0;
    endtask

    task automatic wait_done(input logic exp_cerr);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < 2000 && done_cnt < target; i++) @(posedge clk);
        #1;
        check("frame_done_seen", 32'(done_cnt), 32'(target));
        check("cnt_err_at_done", 32'(done_cerr), 32'(exp_cerr));
        check("busy_low_at_done", 32'(done_busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        tick(2);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_errs", 32'({ovf_err, cnt_err}), 32'd0);
        nrst = 1'b1;
        tick(1);

        // 1: full frame, every other cycle
        wr_ready = 1'b1;
        start_frame(10'h040);
        check("busy_active", 32'(busy), 32'd1);
        for (int i = 0; i < 196; i++) begin
            send(16'($urandom), (i == 195), 1'b1);
            tick(1);
        end
        wait_done(1'b0);
        d0 = done_cnt;
        tick(5);
        check("frame_done_once", 32'(done_cnt), 32'(d0));
        check("t1_ovf", 32'(ovf_err), 32'd0);
        check("t1_last_addr", 32'(exp_addr), 32'h104);

        // 2: back-pressure for 3 cycles with two elements queued
        wr_ready = 1'b0;
        start_frame(10'h010);
        send(16'h1111, 1'b0, 1'b1);
        send(16'h2222, 1'b0, 1'b1);
        tick(1);
        check("t2_wr_valid", 32'(wr_valid), 32'd1);
        check("t2_wr_addr", 32'(wr_addr), 32'h010);
        wr_ready = 1'b1;
        last_only();
        wait_done(1'b1);
        check("t2_ovf", 32'(ovf_err), 32'd0);
        tick(3);
        check("t2_cnt_err_sticky", 32'(cnt_err), 32'd1);

        // 3: overflow with five pushes into four entries
        wr_ready = 1'b0;
        start_frame(10'h200);
        check("t3_errs_cleared", 32'({ovf_err, cnt_err}), 32'd0);
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) send(16'(16'h0A00 + i), 1'b0, (i < 4));
        check("t3_ovf", 32'(ovf_err), 32'd1);
        last_only();
        wr_ready = 1'b1;
        wait_done(1'b1);
        check("t3_write_count", 32'(wr_cnt - w0), 32'd4);
        check("t3_ovf_sticky", 32'(ovf_err), 32'd1);

        // 4: negative element, pushed together with pool_last
        start_frame(10'h300);
        send(16'h1234, 1'b0, 1'b1);
        send(16'hFF80, 1'b1, 1'b1);
        wait_done(1'b1);
`ifdef POOL_OUT_RELU_EN
        check("t4_relu_data", 32'(last_wr_data), 32'h0000);
`else
        check("t4_raw_data", 32'(last_wr_data), 32'hFF80);
`endif

        // 5: reset mid-frame with two entries queued
        wr_ready = 1'b0;
        start_frame(10'h050);
        send(16'h0505, 1'b0, 1'b1);
        send(16'h0606, 1'b0, 1'b1);
        d0 = done_cnt;
        nrst = 1'b0;
        #2;
        check("t5_wr_valid", 32'(wr_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_frame_done", 32'(frame_done), 32'd0);
        sb.delete();
        tick(1);
        nrst = 1'b1;
        tick(2);
        check("t5_fifo_empty", 32'(wr_valid), 32'd0);
        check("t5_no_done", 32'(done_cnt), 32'(d0));
        wr_ready = 1'b1;
        start_frame(10'h060);
        for (int i = 0; i < 196; i++) send(16'(i * 7), (i == 195), 1'b1);
        wait_done(1'b0);
        check("t5_clean_ovf", 32'(ovf_err), 32'd0);

        // 6: short frame, address wrap, ignored start and DRAIN push
        start_frame(10'h3FA);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start = 1'b1;
                base_addr = 10'h111;
            end
            send(16'(16'h0100 + i), 1'b0, 1'b1);
            start = 1'b0;
        end
        check("t6_busy", 32'(busy), 32'd1);
        last_only();
        send(16'h7777, 1'b0, 1'b0);
        wait_done(1'b1);
        check("t6_last_addr", 32'(exp_addr), 32'h004);
        tick(3);
        check("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
